// File: rtl/gates_pkg.sv
// gates_pkg: shared gate-result width and the packed entry type.
// No ports. Exports GATES_WIDTH and gate_result_t {and_v, or_v, xor_v}.
package gates_pkg;
   localparam int GATES_WIDTH = 4;
   typedef struct packed {
      logic [GATES_WIDTH-1:0] and_v;
      logic [GATES_WIDTH-1:0] or_v;
      logic [GATES_WIDTH-1:0] xor_v;
   } gate_result_t;
endpackage

// File: rtl/gates_result_fifo.sv
// gates_result_fifo: first-word-fall-through FIFO of gate results with sticky overflow/consistency flags.
// Ports: clk, rst_n (async active-low), clr (sync flush);
//   in_valid/in_ready with bitwise_and/or/xor (push side);
//   out_valid/out_ready with out_and/or/xor (pop side, zero when empty);
//   count (stored entries), overflow (push while full), mismatch (accepted xor != and^or).
// WIDTH is expected to equal gates_pkg::GATES_WIDTH, since entries are held as gate_result_t.
module gates_result_fifo
   import gates_pkg::*;
#(
   parameter int WIDTH = GATES_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           bitwise_and,
   input  logic [WIDTH-1:0]           bitwise_or,
   input  logic [WIDTH-1:0]           bitwise_xor,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_and,
   output logic [WIDTH-1:0]           out_or,
   output logic [WIDTH-1:0]           out_xor,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       mismatch
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   gate_result_t    mem [DEPTH];
   gate_result_t    head;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            push, pop;
   assign in_ready  = count != CW'(DEPTH);
   assign out_valid = count != '0;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign head      = mem[rd_ptr];
   always_comb begin
      out_and = out_valid ? head.and_v : '0;
      out_or  = out_valid ? head.or_v  : '0;
      out_xor = out_valid ? head.xor_v : '0;
   end
   // Pointers are AW bits wide, so increments wrap modulo DEPTH on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         mismatch <= 1'b0;
      end else if (clr) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         mismatch <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count    <= count + CW'(push) - CW'(pop);
         overflow <= overflow | (in_valid & ~in_ready);
         mismatch <= mismatch | (push & (bitwise_xor != (bitwise_and ^ bitwise_or)));
      end
   end
   // Storage is unreset: stale contents are unreachable once the pointers and count are zero.
   always_ff @(posedge clk) begin
      if (push && !clr) mem[wr_ptr] <= '{and_v: bitwise_and, or_v: bitwise_or, xor_v: bitwise_xor};
   end
endmodule

// File: tb/tb_gates_result_fifo.sv
// tb_gates_result_fifo: table-driven bench with a queue scoreboard for gates_result_fifo.
module tb_gates_result_fifo;
   import gates_pkg::*;
   logic       clk = 0, rst_n = 0, clr = 0, in_valid = 0, out_ready = 0;
   logic [3:0] bitwise_and = 0, bitwise_or = 0, bitwise_xor = 0;
   logic       in_ready, out_valid, overflow, mismatch;
   logic [3:0] out_and, out_or, out_xor;
   logic [2:0] count;
   int         checks = 0, errors = 0, exp_cnt = 0;
   gate_result_t q[$];
   typedef struct {
      logic clr, iv, ordy;
      logic [3:0] a, o, x;
      int   ec;
      logic eov, emm;
   } vec_t;
   vec_t vecs[$];

   gates_result_fifo #(.WIDTH(4), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .bitwise_and(bitwise_and), .bitwise_or(bitwise_or), .bitwise_xor(bitwise_xor),
      .out_valid(out_valid), .out_ready(out_ready), .out_and(out_and), .out_or(out_or),
      .out_xor(out_xor), .count(count), .overflow(overflow), .mismatch(mismatch)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic c, iv, ordy, input logic [3:0] a, o, x,
                               input int ec, input logic eov, emm);
      vec_t v;
      v.clr = c; v.iv = iv; v.ordy = ordy; v.a = a; v.o = o; v.x = x;
      v.ec = ec; v.eov = eov; v.emm = emm;
      return v;
   endfunction

   task automatic step(input vec_t v);
      clr = v.clr; in_valid = v.iv; out_ready = v.ordy;
      bitwise_and = v.a; bitwise_or = v.o; bitwise_xor = v.x;
      #1;
      chk("out_valid", out_valid, exp_cnt != 0);
      chk("in_ready", in_ready, exp_cnt != 4);
      if (exp_cnt != 0) chk("head", {out_and, out_or, out_xor}, q[0]);
      else chk("empty_out", {out_and, out_or, out_xor}, 0);
      if (v.clr) q.delete();
      else begin
         if (v.ordy && exp_cnt != 0) void'(q.pop_front());
         if (v.iv && exp_cnt != 4) q.push_back('{and_v: v.a, or_v: v.o, xor_v: v.x});
      end
      @(posedge clk); #1;
      chk("count", count, v.ec);
      chk("overflow", overflow, v.eov);
      chk("mismatch", mismatch, v.emm);
      exp_cnt = v.ec;
   endtask

   initial begin
      // Main vector table: latency, full/overflow, empty pop, mismatch, clr.
      vecs.push_back(mk(0,1,0,4'h1,4'h7,4'h6,1,0,0));
      vecs.push_back(mk(0,1,0,4'h2,4'h4,4'h6,2,0,0));
      vecs.push_back(mk(0,1,0,4'h3,4'h5,4'h6,3,0,0));
      vecs.push_back(mk(0,1,0,4'h4,4'h8,4'hC,4,0,0));
      vecs.push_back(mk(0,1,0,4'hF,4'hF,4'h0,4,1,0));
      vecs.push_back(mk(0,1,1,4'hE,4'h1,4'hF,3,1,0));
      vecs.push_back(mk(0,0,1,4'h0,4'h0,4'h0,2,1,0));
      vecs.push_back(mk(0,0,1,4'h0,4'h0,4'h0,1,1,0));
      vecs.push_back(mk(0,0,1,4'h0,4'h0,4'h0,0,1,0));
      vecs.push_back(mk(0,0,1,4'h0,4'h0,4'h0,0,1,0));
      vecs.push_back(mk(0,1,1,4'h6,4'h9,4'hF,1,1,0));
      vecs.push_back(mk(0,1,0,4'h3,4'h3,4'h3,2,1,1));
      vecs.push_back(mk(0,1,1,4'h5,4'hA,4'hF,2,1,1));
      vecs.push_back(mk(0,0,1,4'h0,4'h0,4'h0,1,1,1));
      vecs.push_back(mk(1,1,0,4'h7,4'h7,4'h0,0,0,0));
      // Steady push+pop at count 2 across the pointer wrap, then drain.
      for (int i = 0; i < 8; i++) begin
         logic [3:0] a, o;
         a = 4'(i + 1);
         o = 4'(3 * i + 2);
         vecs.push_back(mk(0,1,i >= 2,a,o,a ^ o,2,0,0));
         if (i < 2) vecs[vecs.size()-1].ec = i + 1;
      end
      vecs.push_back(mk(0,0,1,4'h0,4'h0,4'h0,1,0,0));
      vecs.push_back(mk(0,0,1,4'h0,4'h0,4'h0,0,0,0));

      #3;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_count", count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_mismatch", mismatch, 0);
      chk("rst_out", {out_and, out_or, out_xor}, 0);
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      foreach (vecs[i]) step(vecs[i]);

      // Reset dropped between edges with three entries stored.
      for (int i = 0; i < 3; i++) step(mk(0,1,0,4'(i),4'(i+8),4'(8),i + 1,0,0));
      rst_n = 0;
      #1;
      chk("midrst_count", count, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out", {out_and, out_or, out_xor}, 0);
      q.delete();
      exp_cnt = 0;
      in_valid = 0;
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      step(mk(0,1,0,4'hA,4'h5,4'hF,1,0,0));
      step(mk(0,0,1,4'h0,4'h0,4'h0,0,0,0));
      step(mk(1,1,0,4'h9,4'h6,4'hF,0,0,0));
      step(mk(0,0,0,4'h0,4'h0,4'h0,0,0,0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
